keypad_scanner: RTL

Scans a 4x4 matrix keypad, the input-side counterpart of the multiplexed 7-segment refresher. It drives one keypad column low at a time and reads the four rows back, then debounces the result. Each accepted press becomes a 4-bit key code plus a one-cycle strobe. In the elevator design it sits between the board keypad pins and the floor-request logic.

---
 rtl/keypad_scanner.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce and one-cycle key strobe.
// Define KEYPAD_REPEAT_EN to build auto-repeat strobes while a key stays held.
module keypad_scanner #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 20,
    parameter int REPEAT_CNT   = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ROWS,
    output logic [3:0] COLUMNS,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_bad_cfg
        $error("keypad_scanner: illegal parameters");
    end

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

    state_t          r_state;
    logic [3:0]      r_rs_meta, r_rs, r_columns, r_code, r_cand;
    logic [1:0]      r_col;
    logic [TW-1:0]   r_tick;
    logic [DW-1:0]   r_deb, r_rel;
    logic            r_valid, r_held;
`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CNT + 1);
    logic [RW-1:0]   r_rep;
`endif

    logic [3:0] w_low, w_cols_nx, w_code;
    logic [1:0] w_row, w_col_nx;
    logic       w_one, w_tick;

    // exactly one row low is a clean single press; zero or several is ignored as ghosting
    assign w_low     = ~r_rs;
    assign w_one     = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    assign w_row     = w_low[3] ? 2'd3 : w_low[2] ? 2'd2 : w_low[1] ? 2'd1 : 2'd0;
    assign w_code    = {w_row, r_col};
    assign w_tick    = r_tick == TW'(SCAN_DIV - 1);
    assign w_col_nx  = r_col + 2'd1;
    assign w_cols_nx = ~(4'd1 << w_col_nx);

    assign COLUMNS   = r_columns;
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_held  = r_held;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rs_meta <= 4'hF;
            r_rs      <= 4'hF;
            r_tick    <= '0;
            r_col     <= 2'd0;
            r_columns <= 4'b1110;
            r_state   <= SCAN;
            r_cand    <= 4'd0;
            r_code    <= 4'd0;
            r_valid   <= 1'b0;
            r_held    <= 1'b0;
            r_deb     <= '0;
            r_rel     <= '0;
`ifdef KEYPAD_REPEAT_EN
            r_rep     <= '0;
`endif
        end else begin
            r_rs_meta <= ROWS;
            r_rs      <= r_rs_meta;
            r_tick    <= w_tick ? '0 : r_tick + TW'(1);
            r_valid   <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (w_one) begin
                            r_cand <= w_code;
                            if (DEBOUNCE_CNT == 1) begin
                                r_code  <= w_code;
                                r_valid <= 1'b1;
                                r_held  <= 1'b1;
                                r_state <= HOLD;
`ifdef KEYPAD_REPEAT_EN
                                r_rep   <= '0;
`endif
                            end else begin
                                r_deb   <= DW'(1);
                                r_state <= DEBOUNCE;
                            end
                        end else begin
                            r_col     <= w_col_nx;
                            r_columns <= w_cols_nx;
                        end
                    end
                    DEBOUNCE: begin
                        if (w_one && w_row == r_cand[3:2]) begin
                            if (r_deb == DW'(DEBOUNCE_CNT - 1)) begin
                                r_deb   <= '0;
                                r_code  <= r_cand;
                                r_valid <= 1'b1;
                                r_held  <= 1'b1;
                                r_state <= HOLD;
`ifdef KEYPAD_REPEAT_EN
                                r_rep   <= '0;
`endif
                            end else begin
                                r_deb <= r_deb + DW'(1);
                            end
                        end else begin
                            r_deb     <= '0;
                            r_col     <= w_col_nx;
                            r_columns <= w_cols_nx;
                            r_state   <= SCAN;
                        end
                    end
                    HOLD: begin
                        if (r_rs == 4'hF) begin
`ifdef KEYPAD_REPEAT_EN
                            r_rep <= '0;
`endif
                            if (r_rel == DW'(DEBOUNCE_CNT - 1)) begin
                                r_rel     <= '0;
                                r_held    <= 1'b0;
                                r_col     <= w_col_nx;
                                r_columns <= w_cols_nx;
                                r_state   <= SCAN;
                            end else begin
                                r_rel <= r_rel + DW'(1);
                            end
                        end else begin
                            r_rel <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (r_rep == RW'(REPEAT_CNT - 1)) begin
                                r_rep   <= '0;
                                r_valid <= 1'b1;
                            end else begin
                                r_rep <= r_rep + RW'(1);
                            end
`endif
                        end
                    end
                    default: r_state <= SCAN;
                endcase
            end
        end
    end
endmodule
